// File: rtl/hazard_forward_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard/forwarding scoreboard.
// Select encodings and named slot positions used by the forward muxes.
package hazard_forward_scoreboard_pkg;

  localparam int FWD_SEL_REGFILE = 0;
  localparam int SLOT_EX         = 1;
  localparam int SLOT_MEM        = 2;
  localparam int SLOT_WB         = 3;

  // A match in slot k is served by the bus one stage further on; beyond the
  // last tracked slot the regfile (write-through at WB) already has the value.
  function automatic int slot_to_sel(input int k, input int depth);
    return (k + 1 <= depth) ? k + 1 : FWD_SEL_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_forward_scoreboard_fwd_port_select.sv
// Youngest-match search of one read port against the in-flight slots.
// Produces the port's hazard flag and its forward select.
module fwd_port_select
  import hazard_forward_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int LAT_W  = 2,
  parameter int SEL_W  = 2,
  localparam int SLOT_W = 1 + REG_AW + LAT_W
) (
  input  logic [DEPTH*SLOT_W-1:0] slots,
  input  logic [REG_AW-1:0]       rs,
  input  logic                    rs_used,
  output logic                    hazard,
  output logic [SEL_W-1:0]        sel
);

  logic [SLOT_W-1:0] s;

  // Scan oldest to youngest so the lowest matching slot overwrites the rest.
  always_comb begin
    hazard = 1'b0;
    sel    = '0;
    s      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      s = slots[(k-1)*SLOT_W +: SLOT_W];
      if (rs_used && (rs != '0) && s[SLOT_W-1] && (s[LAT_W +: REG_AW] == rs)) begin
        hazard = s[LAT_W-1:0] > LAT_W'(1);
        sel    = SEL_W'(slot_to_sel(k, DEPTH));
      end
    end
  end

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// ID-stage hazard detection and forwarding control: in-flight destination
// shift register with per-entry remaining latency, stall and registered selects.
module hazard_forward_scoreboard
  import hazard_forward_scoreboard_pkg::*;
#(
  parameter int NREAD   = 2,
  parameter int DEPTH   = 3,
  parameter int MAX_LAT = 3,
  parameter int REG_AW  = 5,
  localparam int LAT_W  = $clog2(MAX_LAT + 1),
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [NREAD*REG_AW-1:0] id_rs,
  input  logic [NREAD-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_rd_we,
  input  logic [LAT_W-1:0]        id_lat,
  input  logic                    flush,
  output logic                    stall,
  output logic [NREAD*SEL_W-1:0]  fwd_sel
);

  localparam int SLOT_W = 1 + REG_AW + LAT_W;

  logic [DEPTH*SLOT_W-1:0] slots_q;
  logic [DEPTH*SLOT_W-1:0] slots_d;
  logic [SLOT_W-1:0]       entry;
  logic [SLOT_W-1:0]       prev;
  logic [LAT_W-1:0]        lat_eff;
  logic [NREAD-1:0]        port_hazard;
  logic [NREAD*SEL_W-1:0]  sel_d;
  logic [NREAD*SEL_W-1:0]  fwd_q;
  logic                    issue;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_port_select #(
      .DEPTH (DEPTH),
      .REG_AW(REG_AW),
      .LAT_W (LAT_W),
      .SEL_W (SEL_W)
    ) u_sel (
      .slots  (slots_q),
      .rs     (id_rs[p*REG_AW +: REG_AW]),
      .rs_used(id_rs_used[p]),
      .hazard (port_hazard[p]),
      .sel    (sel_d[p*SEL_W +: SEL_W])
    );
  end

  // Flush dominates: a killed instruction neither stalls nor issues.
  assign stall   = id_valid & ~flush & (|port_hazard);
  assign issue   = id_valid & ~stall & ~flush;
  assign lat_eff = (id_lat == '0) ? LAT_W'(1) : id_lat;

  always_comb begin
    entry = '0;
    if (issue) begin
      entry = {id_rd_we && (id_rd != '0), id_rd, lat_eff};
    end
    slots_d               = '0;
    slots_d[SLOT_W-1:0]   = entry;
    prev                  = '0;
    for (int k = 1; k < DEPTH; k++) begin
      prev = slots_q[(k-1)*SLOT_W +: SLOT_W];
      if (prev[LAT_W-1:0] != '0) begin
        prev[LAT_W-1:0] = prev[LAT_W-1:0] - LAT_W'(1);
      end
      slots_d[k*SLOT_W +: SLOT_W] = prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q <= '0;
      fwd_q   <= '0;
    end else begin
      slots_q <= slots_d;
      fwd_q   <= issue ? sel_d : {NREAD{SEL_W'(FWD_SEL_REGFILE)}};
    end
  end

  assign fwd_sel = fwd_q;

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Bench for hazard_forward_scoreboard: DEPTH=3 and DEPTH=4 instances driven
// in parallel, checked against an age-based reference model plus directed cases.
module tb_hazard_forward_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic [2:0]  id_lat;
  logic        flush;
  logic        stall3, stall4;
  logic [3:0]  fwd3;
  logic [5:0]  fwd4;

  always #5 clk = ~clk;

  hazard_forward_scoreboard #(.NREAD(2), .DEPTH(3), .MAX_LAT(3), .REG_AW(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat(id_lat[1:0]), .flush(flush),
    .stall(stall3), .fwd_sel(fwd3));

  hazard_forward_scoreboard #(.NREAD(2), .DEPTH(4), .MAX_LAT(4), .REG_AW(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat(id_lat), .flush(flush),
    .stall(stall4), .fwd_sel(fwd4));

  // Reference: each issued writer remembered with the cycle it left ID.
  // Its age in a later ID cycle is the number of edges since; the result is
  // available once age reaches its latency, and it is forwardable while tracked.
  typedef struct {
    int rd;
    bit we;
    int lat;
    int cyc;
  } rec_t;

  rec_t q3[$];
  rec_t q4[$];
  int   cyc;
  int   checks;
  int   errors;
  int   fwd_exp [2][2];
  int   pend_sel[2][2];
  bit   pend_issue[2];
  rec_t pend_rec[2];
  int   obs_stall[2];
  int   nst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(input int c);
    return (c == 0) ? 3 : 4;
  endfunction

  function automatic int eff_lat(input int c, input int lat);
    int l;
    l = (c == 0) ? (lat & 3) : lat;
    return (l == 0) ? 1 : l;
  endfunction

  function automatic int obs_sel(input int c, input int p);
    if (c == 0) return int'(fwd3[p*2 +: 2]);
    return int'(fwd4[p*3 +: 3]);
  endfunction

  function automatic void port_eval(input int c, input int rs, input bit used,
                                    output bit hz, output int sel);
    int   n;
    int   age;
    rec_t r;
    hz  = 1'b0;
    sel = 0;
    n   = (c == 0) ? q3.size() : q4.size();
    for (int i = n - 1; i >= 0; i--) begin
      r   = (c == 0) ? q3[i] : q4[i];
      age = cyc - r.cyc;
      if (age >= 1 && age <= depth_of(c) && r.we && r.rd != 0 && used && rs != 0 && r.rd == rs) begin
        hz  = age < r.lat;
        sel = (age + 1 <= depth_of(c)) ? age + 1 : 0;
        return;
      end
    end
  endfunction

  task automatic model_reset();
    q3.delete();
    q4.delete();
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 2; p++) fwd_exp[c][p] = 0;
  endtask

  task automatic drive(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                       input int rd, input bit we, input int lat, input bit fl);
    id_valid   = v;
    id_rs      = {5'(rs1), 5'(rs0)};
    id_rs_used = used;
    id_rd      = 5'(rd);
    id_rd_we   = we;
    id_lat     = 3'(lat);
    flush      = fl;
  endtask

  task automatic mid_check();
    bit hz, anyhz, st;
    int sel;
    for (int c = 0; c < 2; c++) begin
      anyhz = 1'b0;
      for (int p = 0; p < 2; p++) begin
        port_eval(c, int'(id_rs[p*5 +: 5]), id_rs_used[p], hz, sel);
        anyhz = anyhz | hz;
        pend_sel[c][p] = sel;
        check($sformatf("fwd_sel cfg%0d port%0d cyc%0d", c, p, cyc), obs_sel(c, p), fwd_exp[c][p]);
      end
      st = id_valid & ~flush & anyhz;
      obs_stall[c] = (c == 0) ? int'(stall3) : int'(stall4);
      check($sformatf("stall cfg%0d cyc%0d", c, cyc), obs_stall[c], st);
      pend_issue[c] = id_valid & ~flush & ~st;
      pend_rec[c]   = '{rd: int'(id_rd), we: id_rd_we, lat: eff_lat(c, int'(id_lat)), cyc: cyc};
    end
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (pend_issue[c]) begin
        if (c == 0) q3.push_back(pend_rec[c]);
        else        q4.push_back(pend_rec[c]);
      end
      for (int p = 0; p < 2; p++) fwd_exp[c][p] = pend_issue[c] ? pend_sel[c][p] : 0;
    end
    cyc++;
    while (q3.size() > 0 && cyc - q3[0].cyc > 5) void'(q3.pop_front());
    while (q4.size() > 0 && cyc - q4[0].cyc > 5) void'(q4.pop_front());
  endtask

  task automatic step(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                      input int rd, input bit we, input int lat, input bit fl);
    drive(v, rs0, rs1, used, rd, we, lat, fl);
    @(negedge clk);
    mid_check();
    commit();
  endtask

  // Present the same consumer until configuration c lets it issue; n = stall cycles.
  task automatic hold(input int c, input int rs0, input int rs1, input bit [1:0] used,
                      input int rd, input int lat, output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rs0, rs1, used, rd, 1'b1, lat, 1'b0);
      @(negedge clk);
      mid_check();
      commit();
      if (obs_stall[c] == 0) return;
      n++;
    end
    check($sformatf("consumer issue bound cfg%0d", c), obs_stall[c], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 2'b00, 0, 1'b0, 1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset stall cfg0", stall3, 0);
    check("reset fwd_sel cfg0", fwd3, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a stall.
    step(1'b1, 0, 0, 2'b00, 1, 1'b1, 1, 1'b0);
    step(1'b1, 1, 0, 2'b01, 2, 1'b1, 1, 1'b0);
    step(1'b1, 2, 0, 2'b01, 3, 1'b1, 2, 1'b0);
    drive(1'b1, 3, 0, 2'b01, 4, 1'b1, 1, 1'b0);
    @(negedge clk);
    mid_check();
    check("t1 stall before reset", stall3, 1);
    check("t1 fwd before reset", fwd3[1:0], 2);
    #2 rst_n = 1'b0;
    #1;
    check("t1 stall in reset cfg0", stall3, 0);
    check("t1 stall in reset cfg1", stall4, 0);
    check("t1 fwd in reset cfg0", fwd3, 0);
    check("t1 fwd in reset cfg1", fwd4, 0);
    model_reset();
    @(posedge clk);
    #1;
    drive(1'b0, 0, 0, 2'b00, 0, 1'b0, 1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t1 fwd after release", fwd3, 0);
    check("t1 stall after release", stall3, 0);

    // ALU chain.
    step(1'b1, 0, 0, 2'b00, 5, 1'b1, 1, 1'b0);
    step(1'b1, 5, 0, 2'b01, 11, 1'b1, 1, 1'b0);
    check("t2 alu no stall", obs_stall[0], 0);
    check("t2 alu fwd", fwd3[1:0], 2);

    // Load-use.
    step(1'b1, 0, 0, 2'b00, 6, 1'b1, 2, 1'b0);
    hold(0, 0, 6, 2'b10, 16, 1, nst);
    check("t3 load-use stall cycles", nst, 1);
    check("t3 load-use fwd", fwd3[3:2], 3);

    // Youngest wins, x0 and unused ports.
    step(1'b1, 0, 0, 2'b00, 7, 1'b1, 1, 1'b0);
    step(1'b1, 0, 0, 2'b00, 7, 1'b1, 1, 1'b0);
    step(1'b1, 7, 0, 2'b01, 17, 1'b1, 1, 1'b0);
    check("t4 youngest fwd", fwd3[1:0], 2);
    step(1'b1, 0, 0, 2'b00, 0, 1'b1, 2, 1'b0);
    step(1'b1, 0, 0, 2'b11, 18, 1'b1, 1, 1'b0);
    check("t4 x0 no stall", obs_stall[0], 0);
    check("t4 x0 fwd", fwd3, 0);
    step(1'b1, 0, 0, 2'b00, 10, 1'b1, 2, 1'b0);
    step(1'b1, 10, 10, 2'b00, 19, 1'b1, 1, 1'b0);
    check("t4 unused no stall", obs_stall[0], 0);
    check("t4 unused fwd", fwd3, 0);

    // Multi-cycle producers on the deeper configuration.
    step(1'b1, 0, 0, 2'b00, 9, 1'b1, 3, 1'b0);
    hold(1, 9, 0, 2'b01, 20, 1, nst);
    check("t5 lat3 stall cycles", nst, 2);
    check("t5 lat3 fwd", fwd4[2:0], 4);
    step(1'b1, 0, 0, 2'b00, 13, 1'b1, 4, 1'b0);
    hold(1, 13, 0, 2'b01, 21, 1, nst);
    check("t5 lat4 stall cycles", nst, 3);
    check("t5 lat4 fwd", fwd4[2:0], 0);

    // Flush during a load-use stall.
    step(1'b1, 0, 0, 2'b00, 14, 1'b1, 2, 1'b0);
    drive(1'b1, 14, 0, 2'b01, 8, 1'b1, 2, 1'b0);
    @(negedge clk);
    check("t6 stall before flush", stall3, 1);
    flush = 1'b1;
    #1;
    check("t6 stall with flush", stall3, 0);
    mid_check();
    commit();
    check("t6 fwd after flush", fwd3, 0);
    step(1'b1, 8, 12, 2'b11, 15, 1'b1, 1, 1'b0);
    check("t6 unrelated no stall", obs_stall[0], 0);
    check("t6 flushed rd not tracked", fwd3, 0);

    // Randomized traffic over a small register window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 2'($urandom),
           int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 4)),
           ($urandom % 8) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
